dmem_mmio: RTL and testbench

- Data-side responder for the CPU memory access port (`acs_*`).
- Serves loads combinationally in the same cycle, as the single-cycle core requires, and commits stores on the rising clock edge.
- Maps three regions: a byte-maskable RAM, a UART transmit register backed by a FIFO, and a free-running 64-bit timer.
- Sits beside the core at SoC top level. The streaming side (`tx_*`) feeds the serial/console model.

---
 rtl/dmem_pkg.sv | 34 +++
 rtl/dmem_mmio_tx_fifo.sv | 55 +++++
 rtl/dmem_mmio.sv | 112 +++++++++++
 tb/tb_dmem_mmio.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants, status layout and region encoding for the data-side MMIO responder.
package dmem_pkg;

  localparam logic [63:0] DEF_RAM_BASE   = 64'h8000_0000;
  localparam int          DEF_RAM_AW     = 12;
  localparam logic [63:0] DEF_UART_ADDR  = 64'hA000_03F8;
  localparam logic [63:0] DEF_TIMER_ADDR = 64'hA000_0048;
  localparam int          DEF_FIFO_AW    = 3;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 3;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_RAM,
    REG_UART,
    REG_TIMER
  } region_e;

  // Replace each byte lane of old_val whose enable bit is set with the matching lane of new_val.
  function automatic logic [63:0] merge_lanes(input logic [63:0] old_val,
                                              input logic [63:0] new_val,
                                              input logic [7:0]  lanes);
    logic [63:0] r;
    r = old_val;
    for (int i = 0; i < 8; i++) begin
      if (lanes[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_mmio_tx_fifo.sv
// Byte FIFO feeding the UART transmit stream, with a sticky overflow flag.
module tx_fifo #(
  parameter int FIFO_AW = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [7:0]       push_data,
  input  logic             pop,
  output logic [7:0]       head,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic [FIFO_AW:0] count
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full  = (count == (FIFO_AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !do_push) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data-side responder: combinational loads, edge-committed stores over RAM, UART TX FIFO and mtime.
module dmem_mmio
  import dmem_pkg::*;
#(
  parameter logic [63:0] RAM_BASE   = DEF_RAM_BASE,
  parameter int          RAM_AW     = DEF_RAM_AW,
  parameter logic [63:0] UART_ADDR  = DEF_UART_ADDR,
  parameter logic [63:0] TIMER_ADDR = DEF_TIMER_ADDR,
  parameter int          FIFO_AW    = DEF_FIFO_AW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        acs_en,
  input  logic        acs_wr,
  input  logic [7:0]  acs_bytes,
  input  logic [63:0] acs_addr,
  input  logic [63:0] acs_wdata,
  output logic [63:0] acs_rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        fault,
  output logic [63:0] fault_addr
);

  localparam logic [63:0] RAM_END = RAM_BASE + (64'd8 << RAM_AW);

  // Stream handshake: a byte transfers on every rising edge where tx_valid and tx_ready are both
  // high; tx_valid never depends on tx_ready, and tx_data is stable while tx_valid waits.

  logic [63:0]       addr_dw;
  region_e           region;
  logic [RAM_AW-1:0] ram_idx;
  logic [63:0]       mem [1 << RAM_AW];
  logic [63:0]       mtime;
  logic [63:0]       uart_status;
  logic              store;
  logic              uart_push;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_ovf;
  logic [FIFO_AW:0]  fifo_count;

  assign addr_dw = {acs_addr[63:3], 3'b000};
  assign ram_idx = RAM_AW'((addr_dw - RAM_BASE) >> 3);
  assign store   = acs_en && acs_wr;

  always_comb begin
    region = REG_NONE;
    if (addr_dw >= RAM_BASE && addr_dw < RAM_END)      region = REG_RAM;
    else if (acs_addr[63:3] == UART_ADDR[63:3])        region = REG_UART;
    else if (acs_addr[63:3] == TIMER_ADDR[63:3])       region = REG_TIMER;
  end

  always_comb begin
    uart_status = '0;
    uart_status[ST_FULL]  = fifo_full;
    uart_status[ST_EMPTY] = fifo_empty;
    uart_status[ST_OVF]   = fifo_ovf;
    uart_status[ST_CNT_LSB +: FIFO_AW+1] = fifo_count;
  end

  always_comb begin
    acs_rdata = '0;
    if (acs_en) begin
      case (region)
        REG_RAM:   acs_rdata = mem[ram_idx];
        REG_UART:  acs_rdata = uart_status;
        REG_TIMER: acs_rdata = mtime;
        default:   acs_rdata = '0;
      endcase
    end
  end

  // RAM has no reset, so a store presented during reset still lands.
  always_ff @(posedge clk) begin
    if (store && region == REG_RAM) mem[ram_idx] <= merge_lanes(mem[ram_idx], acs_wdata, acs_bytes);
  end

  always_ff @(posedge clk) begin
    if (rst)                            mtime <= '0;
    else if (store && region == REG_TIMER) mtime <= merge_lanes(mtime, acs_wdata, acs_bytes);
    else                                mtime <= mtime + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault      <= 1'b0;
      fault_addr <= '0;
    end else if (acs_en && region == REG_NONE) begin
      fault <= 1'b1;
      if (!fault) fault_addr <= acs_addr;
    end
  end

  assign uart_push = store && region == REG_UART && acs_bytes[0];
  assign tx_valid  = !fifo_empty;

  tx_fifo #(.FIFO_AW(FIFO_AW)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (uart_push),
    .push_data (acs_wdata[7:0]),
    .pop       (tx_valid && tx_ready),
    .head      (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .ovf       (fifo_ovf),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: RAM merge, UART FIFO, timer, fault capture and reset behaviour.
module tb_dmem_mmio;

  localparam logic [63:0] RAM_BASE   = 64'h8000_0000;
  localparam logic [63:0] UART_ADDR  = 64'hA000_03F8;
  localparam logic [63:0] TIMER_ADDR = 64'hA000_0048;

  logic        clk = 1'b0;
  logic        rst;
  logic        acs_en;
  logic        acs_wr;
  logic [7:0]  acs_bytes;
  logic [63:0] acs_addr;
  logic [63:0] acs_wdata;
  logic [63:0] acs_rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        fault;
  logic [63:0] fault_addr;

  int tests_run    = 0;
  int tests_failed = 0;

  dmem_mmio dut (
    .clk        (clk),
    .rst        (rst),
    .acs_en     (acs_en),
    .acs_wr     (acs_wr),
    .acs_bytes  (acs_bytes),
    .acs_addr   (acs_addr),
    .acs_wdata  (acs_wdata),
    .acs_rdata  (acs_rdata),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .fault      (fault),
    .fault_addr (fault_addr)
  );

  always #5 clk = ~clk;

  // One access per cycle: inputs change on the falling edge, outputs are checked 1ns later.
  task automatic drive(input logic en, input logic wr, input logic [7:0] bytes,
                       input logic [63:0] addr, input logic [63:0] data, input logic rdy);
    @(negedge clk);
    acs_en    = en;
    acs_wr    = wr;
    acs_bytes = bytes;
    acs_addr  = addr;
    acs_wdata = data;
    tx_ready  = rdy;
    #1;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1; acs_en = 1'b0; acs_wr = 1'b0; tx_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; acs_en = 1'b1; acs_wr = 1'b0; acs_addr = TIMER_ADDR;
    #1;
    tests_run++; if (acs_rdata !== 64'd0) begin tests_failed++; $display("FAIL reset_mtime got=%h exp=0", acs_rdata); end
    tests_run++; if (fault !== 1'b0) begin tests_failed++; $display("FAIL reset_fault got=%b exp=0", fault); end
    tests_run++; if (fault_addr !== 64'd0) begin tests_failed++; $display("FAIL reset_fault_addr got=%h exp=0", fault_addr); end
    tests_run++; if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    drive(1, 0, 8'h00, TIMER_ADDR, 64'd0, 0);
    tests_run++; if (acs_rdata !== 64'd1) begin tests_failed++; $display("FAIL reset_mtime_inc got=%h exp=1", acs_rdata); end
    drive(1, 0, 8'h00, UART_ADDR, 64'd0, 0);
    tests_run++; if (acs_rdata !== 64'h2) begin tests_failed++; $display("FAIL reset_status got=%h exp=2", acs_rdata); end
    drive(0, 0, 8'h00, TIMER_ADDR, 64'd0, 0);
    tests_run++; if (acs_rdata !== 64'd0) begin tests_failed++; $display("FAIL idle_rdata got=%h exp=0", acs_rdata); end
  endtask

  task automatic test_ram_merge();
    drive(1, 1, 8'hFF, RAM_BASE + 64'h10, 64'h1122_3344_5566_7788, 0);
    drive(1, 1, 8'h04, RAM_BASE + 64'h10, 64'h0000_0000_00AA_0000, 0);
    drive(1, 0, 8'h00, RAM_BASE + 64'h10, 64'd0, 0);
    tests_run++; if (acs_rdata !== 64'h1122_3344_55AA_7788) begin tests_failed++; $display("FAIL ram_merge got=%h exp=1122334455aa7788", acs_rdata); end
    drive(1, 1, 8'hF0, RAM_BASE + 64'h10, 64'hCAFE_BABE_FFFF_FFFF, 0);
    drive(1, 0, 8'h00, RAM_BASE + 64'h14, 64'd0, 0);
    tests_run++; if (acs_rdata !== 64'hCAFE_BABE_55AA_7788) begin tests_failed++; $display("FAIL ram_upper_lanes got=%h exp=cafebabe55aa7788", acs_rdata); end
    drive(1, 1, 8'hFF, RAM_BASE + 64'h7FF8, 64'h0BAD_F00D_1234_5678, 0);
    drive(1, 0, 8'h00, RAM_BASE + 64'h7FF8, 64'd0, 0);
    tests_run++; if (acs_rdata !== 64'h0BAD_F00D_1234_5678) begin tests_failed++; $display("FAIL ram_last_dw got=%h exp=0badf00d12345678", acs_rdata); end
    tests_run++; if (fault !== 1'b0) begin tests_failed++; $display("FAIL ram_no_fault got=%b exp=0", fault); end
  endtask

  task automatic test_uart_fill();
    drive(1, 1, 8'hFE, UART_ADDR, 64'h0000_0000_0000_4200, 0);
    drive(1, 0, 8'h00, UART_ADDR, 64'd0, 0);
    tests_run++; if (acs_rdata !== 64'h2) begin tests_failed++; $display("FAIL uart_lane0_off got=%h exp=2", acs_rdata); end
    for (int i = 0; i < 8; i++) drive(1, 1, 8'h01, UART_ADDR, 64'(8'h41 + i), 0);
    drive(1, 0, 8'h00, UART_ADDR, 64'd0, 0);
    tests_run++; if (acs_rdata !== 64'h41) begin tests_failed++; $display("FAIL uart_full_status got=%h exp=41", acs_rdata); end
    tests_run++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin tests_failed++; $display("FAIL uart_head got=%b/%h exp=1/41", tx_valid, tx_data); end
    drive(1, 1, 8'h01, UART_ADDR, 64'h49, 0);
    drive(1, 0, 8'h00, UART_ADDR, 64'd0, 0);
    tests_run++; if (acs_rdata !== 64'h45) begin tests_failed++; $display("FAIL uart_ovf_status got=%h exp=45", acs_rdata); end
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 8'h00, 64'd0, 64'd0, 1);
      tests_run++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
        tests_failed++; $display("FAIL uart_drain[%0d] got=%b/%h exp=1/%h", i, tx_valid, tx_data, 8'(8'h41 + i));
      end
    end
    drive(1, 0, 8'h00, UART_ADDR, 64'd0, 0);
    tests_run++; if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL uart_drained_valid got=%b exp=0", tx_valid); end
    tests_run++; if (acs_rdata !== 64'h6) begin tests_failed++; $display("FAIL uart_drained_status got=%h exp=6", acs_rdata); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_b;
    pulse_rst();
    for (int i = 0; i < 8; i++) drive(1, 1, 8'h01, UART_ADDR, 64'(8'h10 + i), 0);
    drive(1, 1, 8'h01, UART_ADDR, 64'h5A, 1);
    tests_run++; if (tx_data !== 8'h10) begin tests_failed++; $display("FAIL fpp_head got=%h exp=10", tx_data); end
    drive(1, 0, 8'h00, UART_ADDR, 64'd0, 0);
    tests_run++; if (acs_rdata !== 64'h41) begin tests_failed++; $display("FAIL fpp_status got=%h exp=41", acs_rdata); end
    for (int i = 0; i < 8; i++) begin
      exp_b = (i < 7) ? 8'(8'h11 + i) : 8'h5A;
      drive(0, 0, 8'h00, 64'd0, 64'd0, 1);
      tests_run++;
      if (tx_valid !== 1'b1 || tx_data !== exp_b) begin
        tests_failed++; $display("FAIL fpp_drain[%0d] got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp_b);
      end
    end
    drive(0, 0, 8'h00, 64'd0, 64'd0, 0);
    tests_run++; if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL fpp_empty got=%b exp=0", tx_valid); end
  endtask

  task automatic test_timer();
    drive(1, 1, 8'hFF, TIMER_ADDR, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    drive(1, 0, 8'h00, TIMER_ADDR, 64'd0, 0);
    tests_run++; if (acs_rdata !== 64'hFFFF_FFFF_FFFF_FFFE) begin tests_failed++; $display("FAIL timer_write got=%h exp=fffffffffffffffe", acs_rdata); end
    drive(1, 0, 8'h00, TIMER_ADDR, 64'd0, 0);
    tests_run++; if (acs_rdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin tests_failed++; $display("FAIL timer_max got=%h exp=ffffffffffffffff", acs_rdata); end
    drive(1, 0, 8'h00, TIMER_ADDR, 64'd0, 0);
    tests_run++; if (acs_rdata !== 64'd0) begin tests_failed++; $display("FAIL timer_wrap got=%h exp=0", acs_rdata); end
    drive(1, 1, 8'h02, TIMER_ADDR, 64'h0000_0000_0000_AB00, 0);
    drive(1, 0, 8'h00, TIMER_ADDR, 64'd0, 0);
    tests_run++; if (acs_rdata !== 64'hAB01) begin tests_failed++; $display("FAIL timer_lane_merge got=%h exp=ab01", acs_rdata); end
    drive(1, 0, 8'h00, TIMER_ADDR + 64'h4, 64'd0, 0);
    tests_run++; if (acs_rdata !== 64'hAB02) begin tests_failed++; $display("FAIL timer_next got=%h exp=ab02", acs_rdata); end
  endtask

  task automatic test_fault();
    drive(1, 1, 8'hFF, RAM_BASE, 64'h5555_AAAA_5555_AAAA, 0);
    tests_run++; if (fault !== 1'b0) begin tests_failed++; $display("FAIL fault_initial got=%b exp=0", fault); end
    drive(1, 0, 8'h00, 64'h1000, 64'd0, 0);
    tests_run++; if (acs_rdata !== 64'd0 || fault !== 1'b0) begin tests_failed++; $display("FAIL fault_load got=%h/%b exp=0/0", acs_rdata, fault); end
    drive(1, 1, 8'hFF, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    tests_run++; if (fault !== 1'b1 || fault_addr !== 64'h1000) begin tests_failed++; $display("FAIL fault_capture got=%b/%h exp=1/1000", fault, fault_addr); end
    tests_run++; if (acs_rdata !== 64'd0) begin tests_failed++; $display("FAIL fault_store_rdata got=%h exp=0", acs_rdata); end
    drive(1, 1, 8'hFF, RAM_BASE + 64'h8000, 64'h1234, 0);
    tests_run++; if (fault_addr !== 64'h1000) begin tests_failed++; $display("FAIL fault_sticky_addr got=%h exp=1000", fault_addr); end
    drive(1, 0, 8'h00, RAM_BASE + 64'h8000, 64'd0, 0);
    tests_run++; if (acs_rdata !== 64'd0) begin tests_failed++; $display("FAIL ram_end_unmapped got=%h exp=0", acs_rdata); end
    drive(1, 0, 8'h00, RAM_BASE - 64'h8, 64'd0, 0);
    tests_run++; if (acs_rdata !== 64'd0) begin tests_failed++; $display("FAIL ram_below_unmapped got=%h exp=0", acs_rdata); end
    drive(1, 0, 8'h00, RAM_BASE, 64'd0, 0);
    tests_run++; if (acs_rdata !== 64'h5555_AAAA_5555_AAAA) begin tests_failed++; $display("FAIL fault_store_discard got=%h exp=5555aaaa5555aaaa", acs_rdata); end
    tests_run++; if (fault_addr !== 64'h1000) begin tests_failed++; $display("FAIL fault_addr_hold got=%h exp=1000", fault_addr); end
  endtask

  task automatic test_reset_mid_burst();
    drive(1, 1, 8'hFF, RAM_BASE + 64'h100, 64'hDEAD_BEEF_CAFE_F00D, 0);
    for (int i = 0; i < 3; i++) drive(1, 1, 8'h01, UART_ADDR, 64'(8'h61 + i), 0);
    drive(1, 1, 8'hFF, TIMER_ADDR, 64'h55, 0);
    tests_run++; if (tx_valid !== 1'b1 || fault !== 1'b1) begin tests_failed++; $display("FAIL rmb_pre got=%b/%b exp=1/1", tx_valid, fault); end
    @(negedge clk);
    rst = 1'b1; acs_en = 1'b1; acs_wr = 1'b1; acs_bytes = 8'hFF;
    acs_addr = RAM_BASE + 64'h108; acs_wdata = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    rst = 1'b0; acs_wr = 1'b0; acs_addr = TIMER_ADDR;
    #1;
    tests_run++; if (acs_rdata !== 64'd0) begin tests_failed++; $display("FAIL rmb_mtime0 got=%h exp=0", acs_rdata); end
    tests_run++; if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL rmb_tx_valid got=%b exp=0", tx_valid); end
    tests_run++; if (fault !== 1'b0 || fault_addr !== 64'd0) begin tests_failed++; $display("FAIL rmb_fault got=%b/%h exp=0/0", fault, fault_addr); end
    drive(1, 0, 8'h00, TIMER_ADDR, 64'd0, 0);
    tests_run++; if (acs_rdata !== 64'd1) begin tests_failed++; $display("FAIL rmb_mtime1 got=%h exp=1", acs_rdata); end
    drive(1, 0, 8'h00, UART_ADDR, 64'd0, 0);
    tests_run++; if (acs_rdata !== 64'h2) begin tests_failed++; $display("FAIL rmb_status got=%h exp=2", acs_rdata); end
    drive(1, 0, 8'h00, RAM_BASE + 64'h100, 64'd0, 0);
    tests_run++; if (acs_rdata !== 64'hDEAD_BEEF_CAFE_F00D) begin tests_failed++; $display("FAIL rmb_ram_keep got=%h exp=deadbeefcafef00d", acs_rdata); end
    drive(1, 0, 8'h00, RAM_BASE + 64'h108, 64'd0, 0);
    tests_run++; if (acs_rdata !== 64'h0123_4567_89AB_CDEF) begin tests_failed++; $display("FAIL rmb_ram_in_rst got=%h exp=0123456789abcdef", acs_rdata); end
  endtask

  initial begin
    rst = 1'b1; acs_en = 1'b0; acs_wr = 1'b0; acs_bytes = 8'h00;
    acs_addr = 64'd0; acs_wdata = 64'd0; tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_ram_merge();
    test_uart_fill();
    test_full_push_pop();
    test_timer();
    test_fault();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
